// File: rtl/game_mode_fsm.sv
// game_mode_fsm: game-level controller for the snake game.
// Owns the IDLE/PLAY/OVER/WIN state, the 0..MAX_SCORE score and the snake
// step pulse, whose period shortens as the score rises.
// Optional feature macro: GAME_PAUSE_EN (centre key toggles pause in PLAY).
//
// Handshake/timing contract: every input is a level sampled on the rising
// clock edge; middle and eat act on their rising edge only, hit acts as a
// level. All outputs are registered and change on the edge after the
// qualifying input. The mode output is the FSM state itself and doubles as
// the state debug view.
module game_mode_fsm #(
  parameter int unsigned STEP_BASE = 6_250_000,
  parameter int unsigned STEP_DEC  = 250_000,
  parameter int unsigned STEP_MIN  = 2_500_000,
  parameter int unsigned MAX_SCORE = 15
) (
  input  logic       clk_25MHz,
  input  logic       rst,
  input  logic       middle,
  input  logic       eat,
  input  logic       hit_wall,
  input  logic       hit_self,
  output logic [1:0] mode,
  output logic [3:0] score,
  output logic       step,
  output logic       paused
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10,
    S_WIN  = 2'b11
  } state_t;

  localparam logic [23:0] BASE24 = 24'(STEP_BASE);
  localparam logic [23:0] DEC24  = 24'(STEP_DEC);
  localparam logic [23:0] MIN24  = 24'(STEP_MIN);
  localparam logic [23:0] SPAN24 = BASE24 - MIN24;
  localparam logic [3:0]  MAX4   = 4'(MAX_SCORE);

  state_t      state_q;
  logic [3:0]  score_q;
  logic        step_q;
  logic        paused_q;
  logic [23:0] cnt_q;
  logic        middle_q;
  logic        eat_q;

  logic        mid_rise;
  logic        eat_rise;
  logic        hit;
  logic        pause_req;
  logic [23:0] dec;
  logic [23:0] period;
  logic [23:0] last_cnt;
  logic [3:0]  score_inc;

  assign mid_rise  = middle & ~middle_q;
  assign eat_rise  = eat & ~eat_q;
  assign hit       = hit_wall | hit_self;
  assign score_inc = score_q + 4'd1;

`ifdef GAME_PAUSE_EN
  assign pause_req = mid_rise;
`else
  assign pause_req = 1'b0;
`endif

  // Step period from the current score, clamped at STEP_MIN without underflow.
  always_comb begin
    dec      = 24'(score_q) * DEC24;
    period   = BASE24;
    if (dec >= SPAN24) begin
      period = MIN24;
    end else begin
      period = BASE24 - dec;
    end
    last_cnt = period - 24'd1;
  end

  // Edge-detect history loads the live inputs every cycle, reset included,
  // so a key held through reset or a state change never reads as a press.
  always_ff @(posedge clk_25MHz) begin
    middle_q <= middle;
    eat_q    <= eat;
  end

  // Game FSM with registered mode, score, step pulse, pause flag and step counter.
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state_q  <= S_IDLE;
      score_q  <= 4'd0;
      step_q   <= 1'b0;
      paused_q <= 1'b0;
      cnt_q    <= 24'd0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q    <= 24'd0;
          paused_q <= 1'b0;
          if (mid_rise) begin
            state_q <= S_PLAY;
            score_q <= 4'd0;
          end
        end
        S_PLAY: begin
          if (paused_q) begin
            // Frozen: counter, score and hits all hold; only unpause acts.
            if (pause_req) begin
              paused_q <= 1'b0;
            end
          end else if (hit) begin
            // Hit wins over a coincident eat; score is left untouched.
            state_q <= S_OVER;
            cnt_q   <= 24'd0;
          end else if (pause_req) begin
            // Counter freezes at its current value on the pause edge.
            paused_q <= 1'b1;
          end else if (eat_rise && (score_inc == MAX4)) begin
            score_q <= score_inc;
            state_q <= S_WIN;
            cnt_q   <= 24'd0;
          end else begin
            if (eat_rise && (score_q < MAX4)) begin
              score_q <= score_inc;
            end
            // Compare against the period of the score held this cycle; a new
            // score is seen from the next cycle onward with the same count.
            if (cnt_q >= last_cnt) begin
              step_q <= 1'b1;
              cnt_q  <= 24'd0;
            end else begin
              cnt_q <= cnt_q + 24'd1;
            end
          end
        end
        S_OVER, S_WIN: begin
          cnt_q    <= 24'd0;
          paused_q <= 1'b0;
          if (mid_rise) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mode   = state_q;
  assign score  = score_q;
  assign step   = step_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_game_mode_fsm.sv
// tb_game_mode_fsm: directed scenarios plus randomized stimulus for
// game_mode_fsm, checked every cycle against a behavioural game model.
// Build with +define+GAME_PAUSE_EN to include the pause scenario.
module tb_game_mode_fsm;

  localparam int BASE = 20;
  localparam int DEC  = 2;
  localparam int MINP = 8;
  localparam int MAXS = 3;

`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       middle;
  logic       eat;
  logic       hit_wall;
  logic       hit_self;
  logic [1:0] mode;
  logic [3:0] score;
  logic       step;
  logic       paused;

  always #5 clk = ~clk;

  game_mode_fsm #(
    .STEP_BASE(BASE),
    .STEP_DEC (DEC),
    .STEP_MIN (MINP),
    .MAX_SCORE(MAXS)
  ) dut (
    .clk_25MHz(clk),
    .rst      (rst),
    .middle   (middle),
    .eat      (eat),
    .hit_wall (hit_wall),
    .hit_self (hit_self),
    .mode     (mode),
    .score    (score),
    .step     (step),
    .paused   (paused)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];
  int step_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Game rules: mode 0 idle, 1 play, 2 over, 3 win. The step timer is tracked
  // as "active cycles since entry or last step"; a step is due once that
  // reaches the period of the score held during the cycle.
  int m_mode    = 0;
  int m_score   = 0;
  int m_elapsed = 0;
  bit m_step    = 0;
  bit m_paused  = 0;
  bit m_mid_prev = 0;
  bit m_eat_prev = 0;

  function automatic int period_of(input int s);
    int p;
    p = BASE - s * DEC;
    if (p < MINP) p = MINP;
    return p;
  endfunction

  task automatic model_update(input bit r, input bit m, input bit e, input bit hw, input bit hs);
    bit mr, er, h;
    int p;
    mr = m && !m_mid_prev;
    er = e && !m_eat_prev;
    h  = hw || hs;
    m_mid_prev = m;
    m_eat_prev = e;
    m_step = 0;
    if (r) begin
      m_mode = 0; m_score = 0; m_elapsed = 0; m_paused = 0;
      return;
    end
    case (m_mode)
      0: if (mr) begin m_mode = 1; m_score = 0; m_elapsed = 0; m_paused = 0; end
      1: begin
        if (m_paused) begin
          if (PAUSE_ON && mr) m_paused = 0;
        end else if (h) begin
          m_mode = 2; m_elapsed = 0;
        end else if (PAUSE_ON && mr) begin
          m_paused = 1;
        end else begin
          p = period_of(m_score);
          if (er) begin
            m_score = m_score + 1;
            if (m_score == MAXS) begin m_mode = 3; m_elapsed = 0; end
          end
          if (m_mode == 1) begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed >= p) begin m_step = 1; m_elapsed = 0; end
          end
        end
      end
      default: if (mr) m_mode = 0;
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic tick(input bit r, input bit m, input bit e, input bit hw, input bit hs);
    rst = r; middle = m; eat = e; hit_wall = hw; hit_self = hs;
    model_update(r, m, e, hw, hs);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (step === 1'b1) step_log.push_back(cyc);
    check("mode",   32'(mode),   32'(m_mode));
    check("score",  32'(score),  32'(m_score));
    check("step",   32'(step),   32'(m_step));
    check("paused", 32'(paused), 32'(m_paused));
  endtask

  task automatic run(input int n, input bit m, input bit e, input bit hw, input bit hs);
    for (int i = 0; i < n; i++) tick(1'b0, m, e, hw, hs);
  endtask

  // Compare successive gaps in step_log (relative to a start cycle) against exp_q.
  task automatic check_gaps(input string tag, input int start);
    int prev;
    prev = start;
    while (exp_q.size() > 0) begin
      if (step_log.size() == 0) begin
        check({tag, "_missing"}, 32'd0, 32'(exp_q.pop_front()));
      end else begin
        check(tag, 32'(step_log[0] - prev), 32'(exp_q.pop_front()));
        prev = step_log.pop_front();
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int nsteps;
    bit rm, re, rh, rs, rr;
    rst = 1'b1; middle = 1'b0; eat = 1'b0; hit_wall = 1'b0; hit_self = 1'b0;
    @(negedge clk);

    // Key held through reset must not start the game.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    run(4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("held_no_start", 32'(mode), 32'd0);
    run(1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start; steps every 20 cycles at score 0.
    run(1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("start_mode", 32'(mode), 32'd1);
    t0 = cyc;
    step_log.delete();
    run(45, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'd20);
    exp_q.push_back(8'd20);
    check_gaps("gap_s0", t0);

    // Eat held for 50 cycles scores exactly once; period becomes 18.
    run(50, 1'b0, 1'b1, 1'b0, 1'b0);
    check("eat_hold_score", 32'(score), 32'd1);
    run(1, 1'b0, 1'b0, 1'b0, 1'b0);
    step_log.delete();
    run(40, 1'b0, 1'b0, 1'b0, 1'b0);
    if (step_log.size() >= 2) begin
      t0 = step_log.pop_front();
      exp_q.push_back(8'd18);
      check_gaps("gap_s1", t0);
    end else begin
      check("gap_s1_count", 32'(step_log.size()), 32'd2);
    end

    // Two more pulses reach MAX_SCORE -> WIN; further eats do nothing.
    for (int i = 0; i < 2; i++) begin
      run(1, 1'b0, 1'b1, 1'b0, 1'b0);
      run(2, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("win_mode", 32'(mode), 32'd3);
    check("win_score", 32'(score), 32'd3);
    step_log.delete();
    for (int i = 0; i < 6; i++) begin
      run(1, 1'b0, 1'b1, 1'b1, 1'b0);
      run(4, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("win_score_frozen", 32'(score), 32'd3);
    check("win_no_step", 32'(step_log.size()), 32'd0);

    // WIN -> IDLE keeps score; restart clears it.
    run(1, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_after_win", 32'(mode), 32'd0);
    check("idle_score_held", 32'(score), 32'd3);
    run(1, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_score", 32'(score), 32'd0);

    // Hit and eat rise together at score 1: hit wins.
    run(1, 1'b0, 1'b1, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("hit_mode", 32'(mode), 32'd2);
    check("hit_score", 32'(score), 32'd1);
    run(3, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("over_to_idle", 32'(mode), 32'd0);

    // Reset with a step about to fire clears everything.
    run(1, 1'b1, 1'b0, 1'b0, 1'b0);
    run(19, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_play_mode", 32'(mode), 32'd0);
    check("rst_play_step", 32'(step), 32'd0);
    run(3, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef GAME_PAUSE_EN
    // Pause at count 5; frozen for 100 cycles; resume gives step 15 later.
    run(1, 1'b1, 1'b0, 1'b0, 1'b0);
    run(5, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pause_on", 32'(paused), 32'd1);
    step_log.delete();
    for (int i = 0; i < 20; i++) begin
      run(1, 1'b0, 1'b1, 1'b1, 1'b0);
      run(4, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    check("pause_mode", 32'(mode), 32'd1);
    check("pause_score", 32'(score), 32'd0);
    check("pause_no_step", 32'(step_log.size()), 32'd0);
    run(1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pause_off", 32'(paused), 32'd0);
    t0 = cyc;
    run(20, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'd15);
    check_gaps("resume_gap", t0);
    run(1, 1'b0, 1'b0, 1'b1, 1'b0);
    run(1, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Randomized play checked cycle by cycle against the model.
    rm = 0; re = 0; rh = 0; rs = 0;
    nsteps = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) rm = ~rm;
      if ($urandom_range(0, 5) == 0) re = ~re;
      rh = ($urandom_range(0, 89) == 0);
      rs = ($urandom_range(0, 119) == 0);
      rr = ($urandom_range(0, 499) == 0);
      tick(rr, rm, re, rh, rs);
      if (step === 1'b1) nsteps++;
    end
    if (nsteps == 0) check("rand_steps_seen", 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
